// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EX->MS bus, waits for the data-SRAM
// response, aligns/extends load data and drives WB, decode forwarding and ms_ex.
module mem_stage #(
  parameter int ES_BUS_WD = 161,
  parameter int MS_BUS_WD = 125,
  parameter int FWD_WD    = 42
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ms_allowin,
  input  logic                 es_to_ms_valid,
  input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [MS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                 flush,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  output logic [FWD_WD-1:0]    ms_fwd_bus,
  output logic                 ms_ex
);

  typedef enum logic [2:0] {
    LD_W    = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_WL   = 3'd5,
    LD_WR   = 3'd6,
    LD_NONE = 3'd7
  } ld_type_e;

  logic                 ms_valid;
  logic [ES_BUS_WD-1:0] es_bus_r;
  logic                 buf_valid;
  logic [31:0]          buf_data;
  logic                 discard;

  logic        tlbwi, tlbr, bd, ex, mem_req;
  logic [31:0] badvaddr, rt_old, pc, full_result, final_result, ld_data;
  logic [10:0] c0_bus;
  logic [4:0]  excode, dest;
  logic [3:0]  rf_we;
  logic [1:0]  addr_low;
  ld_type_e    ld_type;
  logic        eret;
  logic        ms_ready_go;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign tlbwi       = es_bus_r[160];
  assign tlbr        = es_bus_r[159];
  assign badvaddr    = es_bus_r[158:127];
  assign c0_bus      = es_bus_r[126:116];
  assign bd          = es_bus_r[115];
  assign ex          = es_bus_r[114];
  assign excode      = es_bus_r[113:109];
  assign rf_we       = es_bus_r[108:105];
  assign dest        = es_bus_r[104:100];
  assign ld_type     = ld_type_e'(es_bus_r[99:97]);
  assign mem_req     = es_bus_r[96];
  assign addr_low    = es_bus_r[95:94];
  assign rt_old      = es_bus_r[93:62];
  assign full_result = {es_bus_r[61:32], addr_low};
  assign pc          = es_bus_r[31:0];
  // eret travels as the top bit of the CP0 sideband bus
  assign eret        = c0_bus[10];

  assign ms_ready_go    = !mem_req || buf_valid || (data_sram_data_ok && !discard);
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_ex          = ms_valid && (ex || eret);

  assign ld_data = buf_valid ? buf_data : data_sram_rdata;

  always_comb begin
    ld_byte = '0;
    unique case (addr_low)
      2'd0: ld_byte = ld_data[7:0];
      2'd1: ld_byte = ld_data[15:8];
      2'd2: ld_byte = ld_data[23:16];
      2'd3: ld_byte = ld_data[31:24];
    endcase
    ld_half = addr_low[1] ? ld_data[31:16] : ld_data[15:0];
  end

  always_comb begin
    final_result = full_result;
    unique case (ld_type)
      LD_W:  final_result = ld_data;
      LD_B:  final_result = {{24{ld_byte[7]}}, ld_byte};
      LD_BU: final_result = {24'd0, ld_byte};
      LD_H:  final_result = {{16{ld_half[15]}}, ld_half};
      LD_HU: final_result = {16'd0, ld_half};
      LD_WL: begin
        unique case (addr_low)
          2'd0: final_result = {ld_data[7:0],  rt_old[23:0]};
          2'd1: final_result = {ld_data[15:0], rt_old[15:0]};
          2'd2: final_result = {ld_data[23:0], rt_old[7:0]};
          2'd3: final_result = ld_data;
        endcase
      end
      LD_WR: begin
        unique case (addr_low)
          2'd0: final_result = ld_data;
          2'd1: final_result = {rt_old[31:24], ld_data[31:8]};
          2'd2: final_result = {rt_old[31:16], ld_data[31:16]};
          2'd3: final_result = {rt_old[31:8],  ld_data[31:24]};
        endcase
      end
      LD_NONE: final_result = full_result;
    endcase
  end

  assign ms_to_ws_bus = ms_valid ?
    {tlbwi, tlbr, badvaddr, c0_bus, bd, ex, excode, rf_we, dest, final_result, pc} : '0;

  assign ms_fwd_bus = ms_valid ?
    {mem_req && !ms_ready_go, rf_we, dest, final_result} : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      es_bus_r <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (flush || (ms_to_ws_valid && ws_allowin)) begin
      buf_valid <= 1'b0;
    end else if (data_sram_data_ok && !discard && ms_valid && !ws_allowin) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  // A flushed load still owes one response; swallow it so the next load waits for its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard <= 1'b0;
    end else if (flush && ms_valid && mem_req && !buf_valid && !data_sram_data_ok) begin
      discard <= 1'b1;
    end else if (data_sram_data_ok && discard) begin
      discard <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load alignment, response buffering,
// flush discard, forwarding/blocking and exception pass-through.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [160:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [124:0] ms_to_ws_bus;
  logic         flush;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [41:0]  ms_fwd_bus;
  logic         ms_ex;

  int tests = 0;
  int fails = 0;
  int handoffs = 0;

  mem_stage #(.ES_BUS_WD(161), .MS_BUS_WD(125), .FWD_WD(42)) dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .flush(flush),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_fwd_bus(ms_fwd_bus), .ms_ex(ms_ex)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) handoffs <= handoffs + 1;
  end

  function automatic logic [160:0] mk_bus(input logic [2:0] ld, input logic req,
                                          input logic [31:0] full, input logic [31:0] rt,
                                          input logic [4:0] dst, input logic [3:0] we,
                                          input logic exc, input logic [4:0] code);
    logic [160:0] b;
    b = '0;
    b[114]     = exc;
    b[113:109] = code;
    b[108:105] = we;
    b[104:100] = dst;
    b[99:97]   = ld;
    b[96]      = req;
    b[95:94]   = full[1:0];
    b[93:62]   = rt;
    b[61:32]   = full[31:2];
    b[31:0]    = 32'hBFC0_0100;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    flush = 1'b0;
    ws_allowin = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    es_to_ms_bus = '0;
    data_sram_rdata = '0;
    step(); step();
    reset = 1'b0;
    #1;
    tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ms_to_ws_valid); end
    tests++; if (ms_to_ws_bus !== '0) begin fails++; $display("FAIL reset_bus got %h want 0", ms_to_ws_bus); end
    tests++; if (ms_fwd_bus !== '0) begin fails++; $display("FAIL reset_fwd got %h want 0", ms_fwd_bus); end
    tests++; if (ms_ex !== 1'b0) begin fails++; $display("FAIL reset_ms_ex got %b want 0", ms_ex); end
    tests++; if (ms_allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin got %b want 1", ms_allowin); end
  endtask

  // Enter one load, return data_ok the following cycle, check the aligned result.
  task automatic one_load(input string name, input logic [2:0] ld, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata, input logic [31:0] exp);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(ld, 1'b1, addr, rt, 5'd3, 4'hF, 1'b0, 5'd0);
    step();
    es_to_ms_valid = 1'b0;
    tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL %s_wait got valid %b want 0", name, ms_to_ws_valid); end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = rdata;
    #1;
    tests++; if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL %s_valid got %b want 1", name, ms_to_ws_valid); end
    tests++; if (ms_to_ws_bus[63:32] !== exp) begin fails++; $display("FAIL %s_result got %h want %h", name, ms_to_ws_bus[63:32], exp); end
    step();
    data_sram_data_ok = 1'b0;
    #1;
    tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL %s_after got valid %b want 0", name, ms_to_ws_valid); end
  endtask

  task automatic test_align();
    one_load("lb",  3'd1, 32'h1000_0003, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80);
    one_load("lbu", 3'd2, 32'h1000_0003, 32'h0, 32'h80FF_1234, 32'h0000_0080);
    one_load("lwl", 3'd5, 32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
    one_load("lwr", 3'd6, 32'h1000_0002, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122);
    one_load("lh",  3'd3, 32'h1000_0002, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001);
    one_load("lhu", 3'd4, 32'h1000_0000, 32'h0, 32'h8001_F00F, 32'h0000_F00F);
  endtask

  task automatic test_buffer();
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 32'h2000_0000, 32'h0, 5'd4, 4'hF, 1'b0, 5'd0);
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5;
    #1;
    tests++; if (ms_allowin !== 1'b0) begin fails++; $display("FAIL buf_allowin0 got %b want 0", ms_allowin); end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h99;
    for (int unsigned i = 0; i < 2; i++) begin
      #1;
      tests++; if (ms_to_ws_bus[63:32] !== 32'h5 || ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL buf_hold got v=%b d=%h want v=1 d=5", ms_to_ws_valid, ms_to_ws_bus[63:32]); end
      tests++; if (ms_allowin !== 1'b0) begin fails++; $display("FAIL buf_allowin got %b want 0", ms_allowin); end
      step();
    end
    ws_allowin = 1'b1;
    #1;
    tests++; if (ms_to_ws_bus[63:32] !== 32'h5) begin fails++; $display("FAIL buf_wb got %h want 5", ms_to_ws_bus[63:32]); end
    tests++; if (ms_allowin !== 1'b1) begin fails++; $display("FAIL buf_release got %b want 1", ms_allowin); end
    step();
    tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL buf_after got %b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_flush_discard();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 32'h3000_0000, 32'h0, 5'd5, 4'hF, 1'b0, 5'd0);
    step();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", ms_to_ws_valid); end
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 32'h3000_0004, 32'h0, 5'd6, 4'hF, 1'b0, 5'd0);
    handoffs = 0;
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD;
    #1;
    tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL discard_first got valid %b want 0", ms_to_ws_valid); end
    tests++; if (ms_fwd_bus[41] !== 1'b1) begin fails++; $display("FAIL discard_blk got %b want 1", ms_fwd_bus[41]); end
    step();
    data_sram_rdata = 32'hBEEF;
    #1;
    tests++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hBEEF) begin fails++; $display("FAIL discard_second got v=%b d=%h want v=1 d=beef", ms_to_ws_valid, ms_to_ws_bus[63:32]); end
    step();
    data_sram_data_ok = 1'b0;
    step();
    tests++; if (handoffs !== 1) begin fails++; $display("FAIL discard_once got %0d want 1", handoffs); end
  endtask

  task automatic test_fwd();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 32'h4000_0000, 32'h0, 5'd7, 4'hF, 1'b0, 5'd0);
    step();
    es_to_ms_valid = 1'b0;
    tests++; if (ms_fwd_bus[41:32] !== {1'b1, 4'hF, 5'd7}) begin fails++; $display("FAIL fwd_pending got %h want %h", ms_fwd_bus[41:32], {1'b1, 4'hF, 5'd7}); end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_5678;
    #1;
    tests++; if (ms_fwd_bus !== {1'b0, 4'hF, 5'd7, 32'h1234_5678}) begin fails++; $display("FAIL fwd_ok got %h want blk=0 data=12345678", ms_fwd_bus); end
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_exception_reset();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(3'd7, 1'b0, 32'h1234_5677, 32'h0, 5'd8, 4'h0, 1'b1, 5'h0C);
    step();
    es_to_ms_valid = 1'b0;
    tests++; if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL ex_valid got %b want 1", ms_to_ws_valid); end
    tests++; if (ms_ex !== 1'b1) begin fails++; $display("FAIL ex_ms_ex got %b want 1", ms_ex); end
    tests++; if (ms_to_ws_bus[78:73] !== {1'b1, 5'h0C}) begin fails++; $display("FAIL ex_code got %h want %h", ms_to_ws_bus[78:73], {1'b1, 5'h0C}); end
    tests++; if (ms_to_ws_bus[63:32] !== 32'h1234_5677) begin fails++; $display("FAIL ex_result got %h want 12345677", ms_to_ws_bus[63:32]); end
    step();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 32'h5000_0000, 32'h0, 5'd9, 4'hF, 1'b0, 5'd0);
    step();
    es_to_ms_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", ms_to_ws_valid); end
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 32'h5000_0004, 32'h0, 5'd9, 4'hF, 1'b0, 5'd0);
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_0001;
    #1;
    tests++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hCAFE_0001) begin fails++; $display("FAIL rst_no_discard got v=%b d=%h want v=1 d=cafe0001", ms_to_ws_valid, ms_to_ws_bus[63:32]); end
    step();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_align();
    test_buffer();
    test_flush_discard();
    test_fwd();
    test_exception_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
